// File: rtl/mux4_pkg.sv
// ---------------------------------------------------------------------------
// mux4_pkg
// Shared definitions for the 4-to-1 round-robin merge stage and the matching
// 1-to-4 demultiplexer. The 2-bit channel code doubles as the output tag
// {sel0, sel1}, so both sides encode and decode lanes the same way.
// ---------------------------------------------------------------------------
package mux4_pkg;

  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] CH_A = 2'b00;
  localparam logic [1:0] CH_B = 2'b01;
  localparam logic [1:0] CH_C = 2'b10;
  localparam logic [1:0] CH_D = 2'b11;

  // Pointer starts on d so that a is searched first after reset.
  localparam logic [1:0] RR_RESET = CH_D;

  // Tag helpers: the code is carried as {sel0, sel1}.
  function automatic logic tag_sel0(input logic [1:0] code);
    return code[1];
  endfunction

  function automatic logic tag_sel1(input logic [1:0] code);
    return code[0];
  endfunction

  function automatic logic [1:0] tag_code(input logic sel0, input logic sel1);
    return {sel0, sel1};
  endfunction

endpackage

// File: rtl/mux4to1_rr_arb4.sv
// ---------------------------------------------------------------------------
// rr_arb4
// Combinational 4-way round-robin arbiter. The search begins at the channel
// after `last` and wraps d -> a; the first requester found wins.
//
// Ports:
//   req     [3:0]  request per channel (bit 0 = a ... bit 3 = d)
//   last    [1:0]  most recently granted channel
//   en             grants allowed this cycle; no grant when low
//   gnt     [3:0]  one-hot grant (all zero when no grant)
//   gnt_idx [1:0]  index of the granted channel (equals last when no grant)
// ---------------------------------------------------------------------------
module rr_arb4
  import mux4_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx
);

  logic       w_found;
  logic [1:0] w_idx;

  always_comb begin
    gnt     = 4'b0000;
    gnt_idx = last;
    w_found = 1'b0;
    w_idx   = last;
    // Offsets 1..4 visit every channel once; offset 4 lands on `last`
    // itself, so a lone requester is granted regardless of the pointer.
    for (int i = 1; i <= 4; i++) begin
      w_idx = last + 2'(i);
      if (en && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4to1_rr.sv
// ---------------------------------------------------------------------------
// mux4to1_rr
// Merges four valid/ready source channels onto one output stream with
// round-robin arbitration and a one-word output register. Each output word
// carries the {sel0, sel1} code of its source lane.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   {a,b,c,d}_valid / _data       source channel word offered
//   {a,b,c,d}_ready               source word accepted this cycle
//   out_valid / out_data          output register contents
//   out_sel0 / out_sel1           source tag of the output word
//   out_ready                     consumer accepts the output word
// ---------------------------------------------------------------------------
module mux4to1_rr
  import mux4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  input  logic             b_valid,
  input  logic             c_valid,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] c_data,
  input  logic [WIDTH-1:0] d_data,
  output logic             a_ready,
  output logic             b_ready,
  output logic             c_ready,
  output logic             d_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel0,
  output logic             out_sel1,
  input  logic             out_ready
);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [1:0]       r_out_code;
  logic [1:0]       r_last;

  logic [3:0]       w_req;
  logic [3:0]       w_gnt;
  logic [1:0]       w_gnt_idx;
  logic             w_load_en;
  logic             w_any_gnt;
  logic [WIDTH-1:0] w_win_data;

  // The register may take a new word when empty or when its word leaves
  // this same cycle, which gives back-to-back transfers with no bubble.
  assign w_load_en = ~r_out_valid | out_ready;
  assign w_req     = {d_valid, c_valid, b_valid, a_valid};
  assign w_any_gnt = |w_gnt;

  rr_arb4 u_arb (
    .req     (w_req),
    .last    (r_last),
    .en      (w_load_en & ~reset),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  always_comb begin
    w_win_data = a_data;
    case (w_gnt_idx)
      CH_A: w_win_data = a_data;
      CH_B: w_win_data = b_data;
      CH_C: w_win_data = c_data;
      CH_D: w_win_data = d_data;
      default: w_win_data = a_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_code  <= CH_A;
      r_last      <= RR_RESET;
    end else if (w_load_en) begin
      if (w_any_gnt) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_data;
        r_out_code  <= w_gnt_idx;
        r_last      <= w_gnt_idx;
      end else begin
        // Drain: data, tag and pointer keep their last values.
        r_out_valid <= 1'b0;
      end
    end
  end

  assign a_ready   = w_gnt[0];
  assign b_ready   = w_gnt[1];
  assign c_ready   = w_gnt[2];
  assign d_ready   = w_gnt[3];
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel0  = tag_sel0(r_out_code);
  assign out_sel1  = tag_sel1(r_out_code);

endmodule
